// File: rtl/turkey_gate_ctrl.sv
// Beam-break gate controller: synchronizes and debounces two sensors, tracks crossings,
// and emits single-cycle up/dw pulses to the turkey counter, refusing pulses that would wrap it.
module turkey_gate_ctrl #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       R,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       UTC,
    input  logic       Z,
    output logic       up,
    output logic       dw,
    output logic       busy,
    output logic [2:0] state_o,
    output logic       sat
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        L_IN   = 3'b001,
        L_BOTH = 3'b010,
        L_OUT  = 3'b011,
        R_IN   = 3'b101,
        R_BOTH = 3'b110,
        R_OUT  = 3'b111
    } state_t;

    localparam logic [7:0] DEB_LIMIT = 8'(DEB_CYCLES);

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    // Bit 1 is the left sensor, bit 0 the right, so w_filt is directly {fL, fR}.
    assign w_raw = {btnL, btnR};

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic       r_sync1;
        logic       r_sync2;
        logic       r_filt;
        logic [7:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!R) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_filt  <= 1'b0;
                r_cnt   <= 8'd0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_filt) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt + 8'd1 == DEB_LIMIT) begin
                    r_filt <= r_sync2;
                    r_cnt  <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end

        assign w_filt[gi] = r_filt;
    end

    state_t r_state;
    state_t w_state_next;
    logic   r_up, r_dw, r_sat, r_busy;
    logic   w_up_next, w_dw_next, w_sat_next;

    always_comb begin
        w_state_next = r_state;
        w_up_next    = 1'b0;
        w_dw_next    = 1'b0;
        w_sat_next   = r_sat;
        case (r_state)
            IDLE: begin
                case (w_filt)
                    2'b10:   w_state_next = L_IN;
                    2'b01:   w_state_next = R_IN;
                    default: ;
                endcase
            end
            L_IN: begin
                case (w_filt)
                    2'b11:        w_state_next = L_BOTH;
                    2'b00, 2'b01: w_state_next = IDLE;
                    default:      ;
                endcase
            end
            L_BOTH: begin
                case (w_filt)
                    2'b01:   w_state_next = L_OUT;
                    2'b10:   w_state_next = L_IN;
                    2'b00:   w_state_next = IDLE;
                    default: ;
                endcase
            end
            L_OUT: begin
                case (w_filt)
                    2'b11: w_state_next = L_BOTH;
                    2'b10: w_state_next = IDLE;
                    2'b00: begin
                        // Completed left-to-right crossing; a full counter would wrap.
                        w_state_next = IDLE;
                        if (!UTC) w_up_next  = 1'b1;
                        else      w_sat_next = 1'b1;
                    end
                    default: ;
                endcase
            end
            R_IN: begin
                case (w_filt)
                    2'b11:        w_state_next = R_BOTH;
                    2'b00, 2'b10: w_state_next = IDLE;
                    default:      ;
                endcase
            end
            R_BOTH: begin
                case (w_filt)
                    2'b10:   w_state_next = R_OUT;
                    2'b01:   w_state_next = R_IN;
                    2'b00:   w_state_next = IDLE;
                    default: ;
                endcase
            end
            R_OUT: begin
                case (w_filt)
                    2'b11: w_state_next = R_BOTH;
                    2'b01: w_state_next = IDLE;
                    2'b00: begin
                        w_state_next = IDLE;
                        if (!Z) w_dw_next  = 1'b1;
                        else    w_sat_next = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            r_state <= IDLE;
            r_up    <= 1'b0;
            r_dw    <= 1'b0;
            r_sat   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_up    <= w_up_next;
            r_dw    <= w_dw_next;
            r_sat   <= w_sat_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    assign up      = r_up;
    assign dw      = r_dw;
    assign sat     = r_sat;
    assign busy    = r_busy;
    assign state_o = r_state;

endmodule

// File: tb/tb_turkey_gate_ctrl.sv
// Scoreboard bench for turkey_gate_ctrl: expected state changes and pulses are queued by the
// stimulus and popped by a negedge monitor whenever the DUT changes state or pulses.
module tb_turkey_gate_ctrl;

    logic       clk = 1'b0;
    logic       R, btnL, btnR, UTC, Z;
    logic       up, dw, busy, sat;
    logic [2:0] state_o;

    turkey_gate_ctrl #(.DEB_CYCLES(4)) dut (
        .clk(clk), .R(R), .btnL(btnL), .btnR(btnR), .UTC(UTC), .Z(Z),
        .up(up), .dw(dw), .busy(busy), .state_o(state_o), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       kind;   // 0: state change, 1: pulse {up,dw}
        logic [2:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_pulse_cyc = 0;
    int   t_start;
    logic mon_en = 1'b0;
    logic [2:0] prev_state = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic mon_pop(input logic kind, input logic [2:0] val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got %0h want none (cycle %0d)",
                     kind ? "pulse" : "state", val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                bad++;
                $display("FAIL scoreboard: got kind=%0d val=%0h want kind=%0d val=%0h (cycle %0d)",
                         kind, val, e.kind, e.val, cyc);
            end else begin
                $display("ok   scoreboard %s=%0h (cycle %0d)", kind ? "pulse" : "state", val, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (state_o !== prev_state) begin
                mon_pop(1'b0, state_o);
                prev_state = state_o;
            end
            if (up === 1'b1 || dw === 1'b1) begin
                mon_pop(1'b1, {1'b0, up, dw});
                chk("busy_at_pulse", {7'd0, busy}, 8'd0);
                last_pulse_cyc = cyc;
            end
        end
    end

    task automatic push_state(input logic [2:0] s);
        exp_q.push_back('{kind: 1'b0, val: s});
    endtask

    task automatic push_pulse(input logic [1:0] p);
        exp_q.push_back('{kind: 1'b1, val: {1'b0, p}});
    endtask

    task automatic hold(input logic [1:0] p, input int n);
        {btnL, btnR} = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic crossing_lr;
        push_state(3'b001); push_state(3'b010); push_state(3'b011); push_state(3'b000);
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    endtask

    task automatic crossing_rl;
        push_state(3'b101); push_state(3'b110); push_state(3'b111); push_state(3'b000);
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    endtask

    task automatic do_reset;
        R = 1'b0;
        {btnL, btnR} = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        R = 1'b0; btnL = 1'b0; btnR = 1'b0; UTC = 1'b0; Z = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {5'd0, state_o}, 8'd0);
        chk("reset_outs", {4'd0, up, dw, busy, sat}, 8'd0);
        R = 1'b1;
        prev_state = state_o;
        mon_en = 1'b1;

        // Left-to-right crossing, including pulse latency and busy while in flight.
        push_state(3'b001); push_state(3'b010); push_state(3'b011); push_state(3'b000);
        push_pulse(2'b10);
        hold(2'b10, 10);
        chk("busy_in_crossing", {7'd0, busy}, 8'd1);
        hold(2'b11, 10); hold(2'b01, 10);
        t_start = cyc;
        hold(2'b00, 10);
        chk("up_latency", 8'(last_pulse_cyc - t_start), 8'd7);
        chk("lr_queue_empty", 8'(exp_q.size()), 8'd0);
        chk("lr_sat", {7'd0, sat}, 8'd0);

        // Right-to-left crossing.
        push_state(3'b101); push_state(3'b110); push_state(3'b111); push_state(3'b000);
        push_pulse(2'b01);
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
        chk("rl_queue_empty", 8'(exp_q.size()), 8'd0);

        // Back-out: enter from left, retreat.
        push_state(3'b001); push_state(3'b010); push_state(3'b001); push_state(3'b000);
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
        chk("backout_queue_empty", 8'(exp_q.size()), 8'd0);

        // Glitch shorter than the filter, then one just long enough.
        hold(2'b10, 3); hold(2'b00, 15);
        chk("glitch_state", {5'd0, state_o}, 8'd0);
        push_state(3'b001); push_state(3'b000);
        hold(2'b10, 5);
        hold(2'b00, 4);
        chk("long_pulse_state", {5'd0, state_o}, 8'd1);
        hold(2'b00, 16);
        chk("glitch_queue_empty", 8'(exp_q.size()), 8'd0);

        // Reset in the middle of a crossing.
        push_state(3'b001); push_state(3'b010); push_state(3'b000);
        hold(2'b10, 10); hold(2'b11, 10);
        chk("pre_reset_state", {5'd0, state_o}, 8'd2);
        do_reset;
        chk("mid_reset_state", {5'd0, state_o}, 8'd0);
        chk("mid_reset_outs", {4'd0, up, dw, busy, sat}, 8'd0);
        R = 1'b1;
        hold(2'b00, 20);
        chk("post_reset_idle", {5'd0, state_o}, 8'd0);
        chk("reset_queue_empty", 8'(exp_q.size()), 8'd0);

        // Saturation: full counter refuses up and sets sat.
        UTC = 1'b1;
        crossing_lr;
        UTC = 1'b0;
        chk("sat_after_utc", {7'd0, sat}, 8'd1);
        push_state(3'b101); push_state(3'b110); push_state(3'b111); push_state(3'b000);
        push_pulse(2'b01);
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
        chk("sat_sticky", {7'd0, sat}, 8'd1);
        chk("sat1_queue_empty", 8'(exp_q.size()), 8'd0);

        do_reset;
        chk("sat_cleared", {7'd0, sat}, 8'd0);
        R = 1'b1;
        hold(2'b00, 2);
        Z = 1'b1;
        crossing_rl;
        Z = 1'b0;
        chk("sat_after_z", {7'd0, sat}, 8'd1);
        chk("sat2_queue_empty", 8'(exp_q.size()), 8'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
